// File: rtl/ddr3_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr3_arb : two-client (write/read) round-robin arbiter in front of a MIG port
// Revision : 1.0
// ----------------------------------------------------------------------------
module ddr3_arb #(
  parameter logic [15:0] p_timeout  = 16'd4096,
  parameter logic        p_wr_first = 1'b1
) (
  input  logic        i_ddr3_clk,
  input  logic        i_rst,
  input  logic        i_init_calib_complete,
  // write client
  input  logic        i_wr_request,
  output logic        o_wr_response,
  input  logic        i_wr_app_en,
  input  logic [2:0]  i_wr_app_cmd,
  input  logic [26:0] i_wr_addr,
  input  logic        i_wr_app_wdf_wren,
  input  logic        i_wr_bust_end,
  // read client
  input  logic        i_rd_request,
  output logic        o_rd_response,
  input  logic        i_rd_app_en,
  input  logic [2:0]  i_rd_app_cmd,
  input  logic [26:0] i_rd_addr,
  input  logic        i_rd_bust_end,
  // MIG side
  output logic        o_app_en,
  output logic [2:0]  o_app_cmd,
  output logic [26:0] o_app_addr,
  output logic        o_app_wdf_wren,
  output logic        o_app_wdf_end,
  // status
  output logic        o_timeout_err,
  output logic [2:0]  o_cs
);

  typedef enum logic [2:0] {
    S_idle    = 3'd0,
    S_wr_busy = 3'd1,
    S_rd_busy = 3'd2,
    S_release = 3'd3
  } state_t;

  localparam logic [15:0] c_wdog_last = p_timeout - 16'd1;

  state_t      state_q, state_d;
  logic        last_wr_q, last_wr_d;
  logic [15:0] wdog_q, wdog_d;
  logic        wr_resp_q, wr_resp_d;
  logic        rd_resp_q, rd_resp_d;
  logic        tmo_q, tmo_d;
  logic        w_own_end;

  always_ff @(posedge i_ddr3_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_idle;
      last_wr_q <= ~p_wr_first;
      wdog_q    <= 16'd0;
      wr_resp_q <= 1'b0;
      rd_resp_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      wdog_q    <= wdog_d;
      wr_resp_q <= wr_resp_d;
      rd_resp_q <= rd_resp_d;
      tmo_q     <= tmo_d;
    end
  end

  // Only the owning client's burst end can close the burst.
  assign w_own_end = (state_q == S_wr_busy) ? i_wr_bust_end : i_rd_bust_end;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    wdog_d    = wdog_q;
    wr_resp_d = 1'b0;
    rd_resp_d = 1'b0;
    tmo_d     = 1'b0;
    case (state_q)
      S_idle: begin
        if (i_init_calib_complete) begin
          if (i_wr_request && (!i_rd_request || !last_wr_q)) begin
            state_d   = S_wr_busy;
            last_wr_d = 1'b1;
            wr_resp_d = 1'b1;
            wdog_d    = 16'd0;
          end else if (i_rd_request) begin
            state_d   = S_rd_busy;
            last_wr_d = 1'b0;
            rd_resp_d = 1'b1;
            wdog_d    = 16'd0;
          end
        end
      end
      S_wr_busy, S_rd_busy: begin
        if (w_own_end) begin
          state_d = S_release;
        end else if (wdog_q == c_wdog_last) begin
          state_d = S_release;
          tmo_d   = 1'b1;
        end else if (wdog_q != 16'hFFFF) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_release: state_d = S_idle;
      default:   state_d = S_idle;
    endcase
  end

  // MIG mux is driven from registered state so reset gates it immediately.
  always_comb begin
    o_app_en       = 1'b0;
    o_app_cmd      = 3'd0;
    o_app_addr     = 27'd0;
    o_app_wdf_wren = 1'b0;
    case (state_q)
      S_wr_busy: begin
        o_app_en       = i_wr_app_en;
        o_app_cmd      = i_wr_app_cmd;
        o_app_addr     = i_wr_addr;
        o_app_wdf_wren = i_wr_app_wdf_wren;
      end
      S_rd_busy: begin
        o_app_en   = i_rd_app_en;
        o_app_cmd  = i_rd_app_cmd;
        o_app_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

  assign o_app_wdf_end = o_app_wdf_wren;
  assign o_wr_response = wr_resp_q;
  assign o_rd_response = rd_resp_q;
  assign o_timeout_err = tmo_q;
  assign o_cs          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ddr3_arb : directed self-checking bench for ddr3_arb (p_timeout = 16)
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_ddr3_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib = 1'b0;
  logic        wr_req = 1'b0, wr_app_en = 1'b0, wr_wren = 1'b0, wr_end = 1'b0;
  logic [2:0]  wr_cmd = 3'd0;
  logic [26:0] wr_addr = 27'd0;
  logic        rd_req = 1'b0, rd_app_en = 1'b0, rd_end = 1'b0;
  logic [2:0]  rd_cmd = 3'd0;
  logic [26:0] rd_addr = 27'd0;
  logic        wr_resp, rd_resp, app_en, app_wren, app_wend, tmo;
  logic [2:0]  app_cmd, cs;
  logic [26:0] app_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ddr3_arb #(.p_timeout(16'd16), .p_wr_first(1'b1)) dut (
    .i_ddr3_clk(clk), .i_rst(rst), .i_init_calib_complete(calib),
    .i_wr_request(wr_req), .o_wr_response(wr_resp), .i_wr_app_en(wr_app_en),
    .i_wr_app_cmd(wr_cmd), .i_wr_addr(wr_addr), .i_wr_app_wdf_wren(wr_wren),
    .i_wr_bust_end(wr_end),
    .i_rd_request(rd_req), .o_rd_response(rd_resp), .i_rd_app_en(rd_app_en),
    .i_rd_app_cmd(rd_cmd), .i_rd_addr(rd_addr), .i_rd_bust_end(rd_end),
    .o_app_en(app_en), .o_app_cmd(app_cmd), .o_app_addr(app_addr),
    .o_app_wdf_wren(app_wren), .o_app_wdf_end(app_wend),
    .o_timeout_err(tmo), .o_cs(cs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // State, both responses and the error pulse in one call.
  task automatic chk_st(input string tag, input logic [2:0] e_cs, input logic e_wr,
                        input logic e_rd, input logic e_tmo);
    chk({tag, ".cs"}, 32'(cs), 32'(e_cs));
    chk({tag, ".wr_resp"}, 32'(wr_resp), 32'(e_wr));
    chk({tag, ".rd_resp"}, 32'(rd_resp), 32'(e_rd));
    chk({tag, ".tmo"}, 32'(tmo), 32'(e_tmo));
  endtask

  initial begin
    // Reset state
    step(); step();
    chk_st("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.app_en", 32'(app_en), 32'd0);
    rst = 1'b0;

    // No grant without calibration; idle mux stays zero
    wr_req = 1'b1; rd_req = 1'b1;
    wr_app_en = 1'b1; wr_wren = 1'b1; wr_addr = 27'h100; wr_cmd = 3'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_st("nocalib", 3'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("idle.app_en", 32'(app_en), 32'd0);
    chk("idle.app_addr", 32'(app_addr), 32'd0);
    chk("idle.wdf_end", 32'(app_wend), 32'd0);

    // Calibration done: write wins first simultaneous request
    calib = 1'b1;
    step();
    chk_st("first_grant", 3'd1, 1'b1, 1'b0, 1'b0);
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    chk_st("wr_busy2", 3'd1, 1'b0, 1'b0, 1'b0);
    chk("wr.app_en", 32'(app_en), 32'd1);
    chk("wr.app_addr", 32'(app_addr), 32'h100);
    chk("wr.wdf_wren", 32'(app_wren), 32'd1);
    chk("wr.wdf_end", 32'(app_wend), 32'd1);
    wr_wren = 1'b0; wr_cmd = 3'd5; #1;
    chk("wr.wdf_end_low", 32'(app_wend), 32'd0);
    chk("wr.app_cmd", 32'(app_cmd), 32'd5);

    // Read client's burst end is ignored while write owns the bus
    rd_end = 1'b1;
    step();
    chk("rd_end_ignored.cs", 32'(cs), 32'd1);
    rd_end = 1'b0; wr_end = 1'b1;
    step();
    chk("wr_release.cs", 32'(cs), 32'd3);
    wr_end = 1'b0;
    step();
    chk("wr_idle.cs", 32'(cs), 32'd0);

    // Continuous requests alternate R,W,R,W (write was served last)
    wr_req = 1'b1; rd_req = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic e_wr;
      e_wr = (b % 2) == 1;
      step();
      chk_st("rr_grant", e_wr ? 3'd1 : 3'd2, e_wr, !e_wr, 1'b0);
      step();
      chk_st("rr_hold", e_wr ? 3'd1 : 3'd2, 1'b0, 1'b0, 1'b0);
      if (e_wr) wr_end = 1'b1; else rd_end = 1'b1;
      step();
      chk_st("rr_release", 3'd3, 1'b0, 1'b0, 1'b0);
      wr_end = 1'b0; rd_end = 1'b0;
      step();
      chk_st("rr_idle", 3'd0, 1'b0, 1'b0, 1'b0);
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Read burst without end: watchdog fires after 16 busy cycles
    rd_req = 1'b1; rd_app_en = 1'b1; rd_cmd = 3'd1; rd_addr = 27'h2AB;
    wr_wren = 1'b1; wr_app_en = 1'b0;
    step();
    chk_st("to_grant", 3'd2, 1'b0, 1'b1, 1'b0);
    chk("rd.app_en", 32'(app_en), 32'd1);
    chk("rd.app_cmd", 32'(app_cmd), 32'd1);
    chk("rd.app_addr", 32'(app_addr), 32'h2AB);
    chk("rd.wdf_wren", 32'(app_wren), 32'd0);
    rd_req = 1'b0; wr_wren = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step();
      chk_st("to_busy", 3'd2, 1'b0, 1'b0, 1'b0);
    end
    step();
    chk_st("to_fire", 3'd3, 1'b0, 1'b0, 1'b1);
    step();
    chk_st("to_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Burst end on the very watchdog cycle: release without error
    wr_req = 1'b1;
    step();
    chk_st("edge_grant", 3'd1, 1'b1, 1'b0, 1'b0);
    wr_req = 1'b0;
    for (int i = 2; i <= 15; i++) begin
      step();
      chk_st("edge_busy", 3'd1, 1'b0, 1'b0, 1'b0);
    end
    step();
    wr_end = 1'b1;
    step();
    chk_st("edge_release", 3'd3, 1'b0, 1'b0, 1'b0);
    wr_end = 1'b0;
    step();
    chk_st("edge_idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // Calibration loss mid-burst does not abort the burst
    rd_req = 1'b1;
    step();
    chk("calib_grant.cs", 32'(cs), 32'd2);
    rd_req = 1'b0; calib = 1'b0;
    step(); step();
    chk("calib_drop.cs", 32'(cs), 32'd2);
    rd_end = 1'b1;
    step();
    chk("calib_drop_rel.cs", 32'(cs), 32'd3);
    rd_end = 1'b0; calib = 1'b1;
    step();

    // Asynchronous reset mid-write burst, then write wins again
    wr_req = 1'b1;
    step();
    chk("rst_grant.cs", 32'(cs), 32'd1);
    wr_req = 1'b0; wr_app_en = 1'b1; wr_wren = 1'b1; #1;
    chk("rst_pre.app_en", 32'(app_en), 32'd1);
    rst = 1'b1; #1;
    chk("rst_async.app_en", 32'(app_en), 32'd0);
    chk("rst_async.wdf_wren", 32'(app_wren), 32'd0);
    chk("rst_async.cs", 32'(cs), 32'd0);
    step();
    rst = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk_st("post_rst_grant", 3'd1, 1'b1, 1'b0, 1'b0);
    wr_req = 1'b0; rd_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ddr3_arb.md
DDR3_ARB -- requirements
Module: ddr3_arb

Interface
REQ-001 SHALL have parameter p_timeout, default 16'd4096, meaning max cycles a granted client may hold the bus without i_*_bust_end.
REQ-002 SHALL have parameter p_wr_first, default 1, meaning write client wins the first simultaneous request after reset.
REQ-003 SHALL have port i_ddr3_clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port i_rst, input, 1; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port i_init_calib_complete, input, 1, MIG calibration done.
REQ-006 SHALL have write-client ports i_wr_request, input, 1; o_wr_response, output, 1; i_wr_app_en, input, 1; i_wr_app_cmd, input, 3; i_wr_addr, input, 27; i_wr_app_wdf_wren, input, 1; i_wr_bust_end, input, 1.
REQ-007 SHALL have read-client ports i_rd_request, input, 1; o_rd_response, output, 1; i_rd_app_en, input, 1; i_rd_app_cmd, input, 3; i_rd_addr, input, 27; i_rd_bust_end, input, 1.
REQ-008 SHALL have MIG ports o_app_en, output, 1; o_app_cmd, output, 3; o_app_addr, output, 27; o_app_wdf_wren, output, 1; o_app_wdf_end, output, 1.
REQ-009 SHALL have status ports o_timeout_err, output, 1 (one-cycle pulse); o_cs, output, 3 (current state).

Function
REQ-010 SHALL implement states S_idle=0, S_wr_busy=1, S_rd_busy=2, S_release=3; all other codes go to S_idle next cycle.
REQ-011 S_idle: with i_init_calib_complete=0 no grant, stay S_idle regardless of requests.
REQ-012 S_idle, calib=1, only i_wr_request=1 -> S_wr_busy; only i_rd_request=1 -> S_rd_busy.
REQ-013 S_idle, both requests=1: grant the client not served last (round-robin flag r_last_wr); after reset flag SHALL favour write when p_wr_first=1, read otherwise.
REQ-014 r_last_wr SHALL update only on grant: 1 on entering S_wr_busy, 0 on entering S_rd_busy.
REQ-015 o_wr_response/o_rd_response SHALL be registered, high exactly one cycle, the first cycle in S_wr_busy/S_rd_busy respectively; never both high.
REQ-016 S_wr_busy: i_wr_bust_end=1 -> S_release; S_rd_busy: i_rd_bust_end=1 -> S_release; bust_end of the non-owner SHALL be ignored.
REQ-017 S_release: one cycle, no grant, -> S_idle; absorbs the client's registered request still high one cycle after response.
REQ-018 Requests in S_wr_busy, S_rd_busy, S_release SHALL be ignored, not latched.
REQ-019 Mux (combinational on registered state): S_wr_busy -> o_app_en=i_wr_app_en, o_app_cmd=i_wr_app_cmd, o_app_addr=i_wr_addr, o_app_wdf_wren=i_wr_app_wdf_wren; S_rd_busy -> o_app_en=i_rd_app_en, o_app_cmd=i_rd_app_cmd, o_app_addr=i_rd_addr, o_app_wdf_wren=0.
REQ-020 S_idle, S_release: o_app_en=0, o_app_wdf_wren=0, o_app_cmd=3'd0, o_app_addr=27'd0.
REQ-021 o_app_wdf_end SHALL equal o_app_wdf_wren (one 256-bit word per burst).
REQ-022 16-bit watchdog SHALL clear on entering a busy state, increment each busy cycle, saturate at 16'hFFFF.
REQ-023 Watchdog == p_timeout-1 in a busy state without owner bust_end -> S_release and o_timeout_err=1 for one cycle; bust_end in that same cycle -> S_release, no error.
REQ-024 i_init_calib_complete falling mid-burst SHALL NOT abort the burst; only new grants are blocked.
REQ-025 o_cs SHALL equal the registered state.

Reset
REQ-026 i_rst=1 SHALL asynchronously force S_idle, watchdog=0, r_last_wr=~p_wr_first, o_wr_response=0, o_rd_response=0, o_timeout_err=0; muxed outputs then follow REQ-020.
REQ-027 Reset mid-burst SHALL drop o_app_en and o_app_wdf_wren to 0 immediately; first grant after release follows REQ-011..013.

Verification
REQ-028 Calib=0, both requests high 10 cycles -> no response, o_cs=0; calib=1 -> o_wr_response pulse next cycle, o_cs=1.
REQ-029 Write grant, i_wr_app_en=1, i_wr_addr=27'h100 -> o_app_en=1, o_app_addr=27'h100, o_app_wdf_end=1 when wdf_wren=1; i_wr_bust_end -> o_cs 3 then 0.
REQ-030 Both requests held continuously -> grants alternate W,R,W,R over 4 bursts; each response pulse exactly one cycle.
REQ-031 Read granted, never bust_end, p_timeout=16 -> o_timeout_err pulse after cycle 16 in S_rd_busy, then S_release, S_idle.
REQ-032 i_rst=1 asserted in S_wr_busy mid-burst -> o_app_en=0 same cycle, o_cs=0; after release, both requested -> write granted first (p_wr_first=1).
REQ-033 i_rd_bust_end pulsed during S_wr_busy -> ignored, o_cs stays 1 until i_wr_bust_end.
